// File: rtl/dot_product_pkg.sv
// Shared constants and types for the dot_product_8_8x8 datapath and its feeder.
//   N : bits per element
//   M : elements per word (word width is M*N)
//   A : B memory address width (longest vector is 2**A-1 words)
//   S : accumulator width of the downstream dot-product stage
//   feed_state_t : feeder sequencer states
package dot_product_pkg;

  localparam int N = 8;
  localparam int M = 8;
  localparam int A = 10;
  localparam int S = 48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feed_state_t;

endpackage

// File: rtl/dot_product_8_8x8_feeder_addr_counter.sv
// dp_feed_addr_counter: A-bit word index for the feeder.
// Loads a start value, increments on each accepted word and wraps to zero after
// the word at limit-1, so one counter serves both the B load and the A stream.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load, load_val  force idx to load_val (takes priority over inc)
//   inc             advance idx by one word
//   limit           vector length in words
//   idx             current word index
//   is_first        idx is the first word of a vector
//   is_last         idx is the last word of a vector
module dp_feed_addr_counter #(
  parameter int A = dot_product_pkg::A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [A-1:0] load_val,
  input  logic         inc,
  input  logic [A-1:0] limit,
  output logic [A-1:0] idx,
  output logic         is_first,
  output logic         is_last
);

  assign is_first = (idx == '0);
  // Unsigned compare; limit is never 0 while the counter is in use.
  assign is_last  = (idx == limit - A'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= load_val;
    end else if (inc) begin
      idx <= is_last ? '0 : idx + A'(1);
    end
  end

endmodule

// File: rtl/dot_product_8_8x8_feeder.sv
// dot_product_8_8x8_feeder: upstream sequencer for dot_product_8_8x8.
// Loads i_len B words into the dot-product B memory, then streams A words with the
// matching B read address and first/last framing. i_reload lets the current A
// vector finish before a new B vector is loaded.
// Ports:
//   i_clk, i_reset           clock, asynchronous active-high reset
//   i_start, i_reload, i_len control pulses and vector length
//   i_b_data/valid, o_b_ready B load stream
//   i_a_data/valid, o_a_ready A stream
//   o_a, o_b, o_b_addr, o_wren, o_first, o_last  registered dot-product controls
//   o_busy       sequencer not idle
//   o_cfg_err    one-cycle pulse on a zero-length start/reload
//   o_vec_count  completed A vectors since reset
module dot_product_8_8x8_feeder
  import dot_product_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic           i_reload,
  input  logic [A-1:0]   i_len,
  input  logic [M*N-1:0] i_b_data,
  input  logic           i_b_valid,
  output logic           o_b_ready,
  input  logic [M*N-1:0] i_a_data,
  input  logic           i_a_valid,
  output logic           o_a_ready,
  output logic [M*N-1:0] o_a,
  output logic [M*N-1:0] o_b,
  output logic [A-1:0]   o_b_addr,
  output logic           o_wren,
  output logic           o_first,
  output logic           o_last,
  output logic           o_busy,
  output logic           o_cfg_err,
  output logic [31:0]    o_vec_count
);

  feed_state_t  state, state_nx;
  logic [A-1:0] idx, len_q, len_pend, len_nx;
  logic         is_first, is_last;
  logic         cnt_load, len_load, pend_load, cfg_err_nx;
  logic         b_xfer, a_xfer;

  assign o_b_ready = (state == LOAD_B);
  assign o_a_ready = (state == STREAM) || (state == DRAIN);
  assign o_busy    = (state != IDLE);
  assign b_xfer    = i_b_valid && o_b_ready;
  assign a_xfer    = i_a_valid && o_a_ready;

  dp_feed_addr_counter #(.A(A)) u_addr (
    .clk      (i_clk),
    .rst      (i_reset),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (b_xfer || a_xfer),
    .limit    (len_q),
    .idx      (idx),
    .is_first (is_first),
    .is_last  (is_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      len_q    <= '0;
      len_pend <= '0;
    end else begin
      state <= state_nx;
      if (len_load)  len_q    <= len_nx;
      if (pend_load) len_pend <= i_len;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_load   = 1'b0;
    len_load   = 1'b0;
    len_nx     = len_q;
    pend_load  = 1'b0;
    cfg_err_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            cfg_err_nx = 1'b1;
          end else begin
            state_nx = LOAD_B;
            cnt_load = 1'b1;
            len_load = 1'b1;
            len_nx   = i_len;
          end
        end
      end
      LOAD_B: begin
        if (b_xfer && is_last) state_nx = STREAM;
      end
      STREAM: begin
        if (i_reload) begin
          if (i_len == '0) begin
            cfg_err_nx = 1'b1;
          end else if ((a_xfer && is_last) || (!a_xfer && is_first)) begin
            // Vector boundary: either nothing in flight, or this word closes
            // the vector. Reload B directly with the new length.
            state_nx = LOAD_B;
            len_load = 1'b1;
            len_nx   = i_len;
          end else begin
            // Keep the old length until the drain finishes the current vector.
            state_nx  = DRAIN;
            pend_load = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (a_xfer && is_last) begin
          state_nx = LOAD_B;
          len_load = 1'b1;
          len_nx   = len_pend;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- output register stage: one cycle after the accepted transfer ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_a         <= '0;
      o_b         <= '0;
      o_b_addr    <= '0;
      o_wren      <= 1'b0;
      o_first     <= 1'b0;
      o_last      <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_vec_count <= '0;
    end else begin
      o_wren    <= b_xfer;
      o_cfg_err <= cfg_err_nx;
      if (b_xfer) begin
        o_b      <= i_b_data;
        o_b_addr <= idx;
      end else if (a_xfer) begin
        o_b_addr <= idx;
      end
      // A bubble presents a zero word so the accumulator is unaffected.
      if (a_xfer) begin
        o_a     <= i_a_data;
        o_first <= is_first;
        o_last  <= is_last;
      end else begin
        o_a     <= '0;
        o_first <= 1'b0;
        o_last  <= 1'b0;
      end
      o_vec_count <= o_vec_count + 32'(o_last);
    end
  end

endmodule

// File: tb/tb_dot_product_8_8x8_feeder.sv
// Testbench for dot_product_8_8x8_feeder: directed sequence with random data,
// checked against dot products computed directly from the stimulus vectors.
module tb_dot_product_8_8x8_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, reload = 1'b0;
  logic [9:0]  len = '0;
  logic [63:0] b_data = '0, a_data = '0;
  logic        b_valid = 1'b0, a_valid = 1'b0;
  logic        b_ready, a_ready;
  logic [63:0] o_a, o_b;
  logic [9:0]  o_b_addr;
  logic        o_wren, o_first, o_last, o_busy, o_cfg_err;
  logic [31:0] o_vec_count;

  always #5 clk = ~clk;

  dot_product_8_8x8_feeder dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_reload    (reload),
    .i_len       (len),
    .i_b_data    (b_data),
    .i_b_valid   (b_valid),
    .o_b_ready   (b_ready),
    .i_a_data    (a_data),
    .i_a_valid   (a_valid),
    .o_a_ready   (a_ready),
    .o_a         (o_a),
    .o_b         (o_b),
    .o_b_addr    (o_b_addr),
    .o_wren      (o_wren),
    .o_first     (o_first),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_cfg_err   (o_cfg_err),
    .o_vec_count (o_vec_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Signed 8x8 element-wise dot product of two 64-bit words.
  function automatic longint word_dot(input logic [63:0] a, input logic [63:0] b);
    longint s = 0;
    logic signed [7:0] ea, eb;
    for (int m = 0; m < 8; m++) begin
      ea = a[m*8 +: 8];
      eb = b[m*8 +: 8];
      s += longint'(ea) * longint'(eb);
    end
    return s;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom} | 64'h1;
  endfunction

  // Downstream consumer: B memory plus accumulator framed by first/last.
  logic [63:0] bmem [0:1023];
  longint      acc = 0;
  logic [9:0]  first_reg = '0;
  longint      sums [0:63];
  logic [9:0]  fa [0:63];
  logic [9:0]  la [0:63];
  int n_sums = 0, n_wren = 0, n_overlap = 0, n_cfg = 0, n_busy = 0;

  always @(negedge clk) begin
    if (o_wren) begin
      bmem[o_b_addr] <= o_b;
      n_wren <= n_wren + 1;
    end
    if (o_wren && (o_first || o_last)) n_overlap <= n_overlap + 1;
    if (o_cfg_err) n_cfg <= n_cfg + 1;
    if (o_busy) n_busy <= n_busy + 1;
    if (o_first) first_reg <= o_b_addr;
    acc <= (o_first ? 64'sd0 : acc) + word_dot(o_a, bmem[o_b_addr]);
    if (o_last && n_sums < 64) begin
      sums[n_sums] <= (o_first ? 64'sd0 : acc) + word_dot(o_a, bmem[o_b_addr]);
      fa[n_sums]   <= o_first ? o_b_addr : first_reg;
      la[n_sums]   <= o_b_addr;
      n_sums       <= n_sums + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; reload = 1'b0; b_valid = 1'b0; a_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_start(input logic [9:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] d, input bit gaps);
    bit ok = 1'b0;
    if (gaps && $urandom_range(0, 1) == 1) step();
    b_data  = d;
    b_valid = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      ok = b_ready;
      step();
    end
    b_valid = 1'b0;
    b_data  = '0;
    check("b_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_a(input logic [63:0] d, input bit gaps, input bit rl, input logic [9:0] rlen);
    bit ok = 1'b0;
    if (gaps && $urandom_range(0, 1) == 1) step();
    a_data  = d;
    a_valid = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      ok = a_ready;
      if (ok && rl) begin
        reload = 1'b1;
        len    = rlen;
      end
      step();
    end
    reload  = 1'b0;
    a_valid = 1'b0;
    a_data  = '0;
    check("a_accept", 64'(ok), 64'd1);
  endtask

  initial begin
    logic [63:0] bw [8];
    logic [63:0] w;
    longint      es [4];
    int          base, wb, cb, bb;

    // Reset state
    step();
    step();
    check("rst_a", o_a, 64'd0);
    check("rst_b", o_b, 64'd0);
    check("rst_ctl", 64'({o_b_addr, o_wren, o_first, o_last, o_busy, o_cfg_err, b_ready, a_ready}), 64'd0);
    check("rst_vec_count", 64'(o_vec_count), 64'd0);
    do_reset();

    // Test 1: len 4, B = {1,2,3,4}, three A vectors
    base = n_sums; wb = n_wren;
    pulse_start(10'd4);
    for (int k = 0; k < 4; k++) begin
      bw[k] = 64'(k + 1);
      send_b(bw[k], 1'b0);
    end
    for (int v = 0; v < 3; v++) begin
      es[v] = 0;
      for (int k = 0; k < 4; k++) begin
        w = rnd64();
        es[v] += word_dot(w, bw[k]);
        send_a(w, 1'b0, 1'b0, 10'd0);
      end
    end
    repeat (3) step();
    check("t1_nsums", 64'(n_sums - base), 64'd3);
    for (int v = 0; v < 3; v++) begin
      check("t1_sum", sums[base+v], es[v]);
      check("t1_first_addr", 64'(fa[base+v]), 64'd0);
      check("t1_last_addr", 64'(la[base+v]), 64'd3);
    end
    check("t1_vec_count", 64'(o_vec_count), 64'd3);
    check("t1_wren", 64'(n_wren - wb), 64'd4);

    // Test 2: len 8 with random gaps on both streams
    do_reset();
    base = n_sums; wb = n_wren;
    pulse_start(10'd8);
    for (int k = 0; k < 8; k++) begin
      bw[k] = rnd64();
      send_b(bw[k], 1'b1);
    end
    for (int v = 0; v < 2; v++) begin
      es[v] = 0;
      for (int k = 0; k < 8; k++) begin
        w = rnd64();
        es[v] += word_dot(w, bw[k]);
        send_a(w, 1'b1, 1'b0, 10'd0);
      end
    end
    repeat (3) step();
    check("t2_nsums", 64'(n_sums - base), 64'd2);
    check("t2_sum0", sums[base], es[0]);
    check("t2_sum1", sums[base+1], es[1]);
    check("t2_wren", 64'(n_wren - wb), 64'd8);
    check("t2_vec_count", 64'(o_vec_count), 64'd2);

    // Test 3: zero-length start
    do_reset();
    cb = n_cfg; bb = n_busy;
    pulse_start(10'd0);
    repeat (4) step();
    check("t3_cfg_err_pulses", 64'(n_cfg - cb), 64'd1);
    check("t3_busy_cycles", 64'(n_busy - bb), 64'd0);
    check("t3_b_ready", 64'(b_ready), 64'd0);

    // Test 4: reload at idx 2 of len 5, new length 2
    do_reset();
    base = n_sums;
    pulse_start(10'd5);
    for (int k = 0; k < 5; k++) begin
      bw[k] = rnd64();
      send_b(bw[k], 1'b0);
    end
    es[0] = 0;
    for (int k = 0; k < 5; k++) begin
      w = rnd64();
      es[0] += word_dot(w, bw[k]);
      send_a(w, 1'b0, k == 2, 10'd2);
      if (k == 2) len = 10'd7;
    end
    check("t4_b_ready_after_drain", 64'(b_ready), 64'd1);
    check("t4_a_ready_after_drain", 64'(a_ready), 64'd0);
    for (int k = 0; k < 2; k++) begin
      bw[k] = rnd64();
      send_b(bw[k], 1'b0);
    end
    es[1] = 0;
    for (int k = 0; k < 2; k++) begin
      w = rnd64();
      es[1] += word_dot(w, bw[k]);
      send_a(w, 1'b0, 1'b0, 10'd0);
    end
    repeat (3) step();
    check("t4_nsums", 64'(n_sums - base), 64'd2);
    check("t4_sum_old", sums[base], es[0]);
    check("t4_sum_new", sums[base+1], es[1]);
    check("t4_new_last_addr", 64'(la[base+1]), 64'd1);
    check("t4_vec_count", 64'(o_vec_count), 64'd2);

    // Test 5: len 1, every word is first and last
    do_reset();
    base = n_sums;
    pulse_start(10'd1);
    bw[0] = rnd64();
    send_b(bw[0], 1'b0);
    for (int v = 0; v < 4; v++) begin
      w = rnd64();
      es[v] = word_dot(w, bw[0]);
      send_a(w, 1'b0, 1'b0, 10'd0);
    end
    repeat (3) step();
    check("t5_nsums", 64'(n_sums - base), 64'd4);
    for (int v = 0; v < 4; v++) begin
      check("t5_sum", sums[base+v], es[v]);
      check("t5_first_addr", 64'(fa[base+v]), 64'd0);
      check("t5_last_addr", 64'(la[base+v]), 64'd0);
    end
    check("t5_vec_count", 64'(o_vec_count), 64'd4);

    // Test 6: reset mid-stream, then a clean run
    do_reset();
    pulse_start(10'd4);
    for (int k = 0; k < 4; k++) begin
      bw[k] = rnd64();
      send_b(bw[k], 1'b0);
    end
    for (int k = 0; k < 2; k++) send_a(rnd64(), 1'b0, 1'b0, 10'd0);
    check("t6_busy_before", 64'(o_busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_a", o_a, 64'd0);
    check("t6_rst_b", o_b, 64'd0);
    check("t6_rst_ctl", 64'({o_b_addr, o_wren, o_first, o_last, o_busy, o_cfg_err, b_ready, a_ready}), 64'd0);
    step();
    rst = 1'b0;
    step();
    base = n_sums;
    pulse_start(10'd3);
    for (int k = 0; k < 3; k++) begin
      bw[k] = rnd64();
      send_b(bw[k], 1'b0);
    end
    es[0] = 0;
    for (int k = 0; k < 3; k++) begin
      w = rnd64();
      es[0] += word_dot(w, bw[k]);
      send_a(w, 1'b0, 1'b0, 10'd0);
    end
    repeat (3) step();
    check("t6_nsums", 64'(n_sums - base), 64'd1);
    check("t6_sum", sums[base], es[0]);
    check("t6_vec_count", 64'(o_vec_count), 64'd1);

    check("wren_first_last_overlap", 64'(n_overlap), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, vectors %0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
